// File: rtl/wf_burst_feeder.sv
// Burst feeder: buffers a word stream in a show-ahead FIFO and slices each frame
// into bursts for an Avalon-MM burst writer (ctrl_start / ctrl_busy / ctrl_read).
module wf_burst_feeder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_WIDTH   = 4,
  parameter int BURST_COUNT   = 8,
  parameter int FIFO_AW       = 5,
  parameter int FRAME_WIDTH   = 20
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     frame_start,
  input  logic [ADDRESS_WIDTH-1:0] frame_base,
  input  logic [FRAME_WIDTH-1:0]   frame_words,
  output logic                     frame_active,
  output logic                     frame_done,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     wr_start,
  output logic [ADDRESS_WIDTH-1:0] wr_baseaddress,
  output logic [BURST_WIDTH-1:0]   wr_burstcount,
  input  logic                     wr_busy,
  input  logic                     wr_read,
  output logic [DATA_WIDTH-1:0]    wr_writedata,
  output logic                     underflow
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [FIFO_AW:0]         DEPTH_C = (FIFO_AW+1)'(DEPTH);
  localparam logic [FRAME_WIDTH-1:0]   BC_F    = FRAME_WIDTH'(BURST_COUNT);
  localparam logic [ADDRESS_WIDTH-1:0] BYTES_A = ADDRESS_WIDTH'(BYTES);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARM, S_BURST, S_DONE} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [FIFO_AW-1:0]       wptr_q, rptr_q;
  logic [FIFO_AW:0]         count_q;
  logic                     push, pop, underflow_q;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [FRAME_WIDTH-1:0]   remaining_q, remaining_d;
  logic [FRAME_WIDTH-1:0]   words_q, words_d;
  logic [FRAME_WIDTH-1:0]   accepted_q, accepted_d;
  logic [BURST_WIDTH-1:0]   len_q, len_d;
  logic                     active_q, active_d;

  function automatic logic [BURST_WIDTH-1:0] burst_len(input logic [FRAME_WIDTH-1:0] rem);
    if (rem < BC_F) return BURST_WIDTH'(rem);
    return BURST_WIDTH'(BURST_COUNT);
  endfunction

  assign in_ready       = active_q && (count_q < DEPTH_C) && (accepted_q < words_q);
  assign push           = in_valid && in_ready;
  assign pop            = wr_read && (count_q != '0);
  assign wr_writedata   = mem_q[rptr_q];
  assign frame_active   = active_q;
  assign wr_baseaddress = addr_q;
  assign wr_burstcount  = len_q;
  assign underflow      = underflow_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

  // A read against an empty FIFO never moves the pointers; it only latches the flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + FIFO_AW'(1);
      if (pop)  rptr_q <= rptr_q + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (wr_read && (count_q == '0)) underflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      accepted_q  <= '0;
      len_q       <= '0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
      accepted_q  <= accepted_d;
      len_q       <= len_d;
      active_q    <= active_d;
    end
  end

  // len_q is computed on entry to FILL so wr_burstcount is stable from wr_start to burst end.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    words_d     = words_q;
    accepted_d  = accepted_q;
    len_d       = len_q;
    active_d    = active_q;
    wr_start    = 1'b0;
    frame_done  = 1'b0;
    if (push) accepted_d = accepted_q + FRAME_WIDTH'(1);
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          if (frame_words == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d      = frame_base;
            remaining_d = frame_words;
            words_d     = frame_words;
            accepted_d  = '0;
            len_d       = burst_len(frame_words);
            active_d    = 1'b1;
            state_d     = S_FILL;
          end
        end
      end
      S_FILL: begin
        if ((32'(count_q) >= 32'(len_q)) && !wr_busy) begin
          wr_start = 1'b1;
          state_d  = S_ARM;
        end
      end
      S_ARM: begin
        if (wr_busy) state_d = S_BURST;
      end
      S_BURST: begin
        if (!wr_busy) begin
          addr_d      = addr_q + ADDRESS_WIDTH'(len_q) * BYTES_A;
          remaining_d = remaining_q - FRAME_WIDTH'(len_q);
          len_d       = burst_len(remaining_d);
          state_d     = (remaining_d == '0) ? S_DONE : S_FILL;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        active_d   = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_wf_burst_feeder.sv
// Directed bench for wf_burst_feeder: stream driver tasks, a burst-writer model and
// per-scenario checks against hand-computed burst addresses, lengths and data order.
`timescale 1ns/1ps
module tb_wf_burst_feeder;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int FW = 20;

  logic          clk, reset_n;
  logic          frame_start;
  logic [AW-1:0] frame_base;
  logic [FW-1:0] frame_words;
  logic          frame_active, frame_done;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          wr_start;
  logic [AW-1:0] wr_baseaddress;
  logic [BW-1:0] wr_burstcount;
  logic          wr_busy, wr_read;
  logic [DW-1:0] wr_writedata;
  logic          underflow;

  int vectors, miscompares;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] st_base_q[$];
  logic [BW-1:0] st_bc_q[$];
  logic [DW-1:0] rx_data_q[$];
  logic [BW-1:0] rx_bc_q[$];
  logic [AW-1:0] rx_base_q[$];
  int st_idx, rx_idx;
  logic rd_en, rand_wait;
  int poke_req, poke_ack, done_cnt, w_st, beats;

  wf_burst_feeder dut (
    .clk(clk), .reset_n(reset_n),
    .frame_start(frame_start), .frame_base(frame_base), .frame_words(frame_words),
    .frame_active(frame_active), .frame_done(frame_done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_start(wr_start), .wr_baseaddress(wr_baseaddress), .wr_burstcount(wr_burstcount),
    .wr_busy(wr_busy), .wr_read(wr_read), .wr_writedata(wr_writedata),
    .underflow(underflow)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Burst writer model: sees wr_start, raises busy next cycle, reads burstcount words.
  always @(negedge clk) begin
    if (!reset_n) begin
      wr_busy = 1'b0;
      wr_read = 1'b0;
      w_st    = 0;
      beats   = 0;
    end else begin
      wr_read = 1'b0;
      if (frame_done) done_cnt++;
      case (w_st)
        0: begin
          if (wr_start) begin
            st_base_q.push_back(wr_baseaddress);
            st_bc_q.push_back(wr_burstcount);
            beats = int'(wr_burstcount);
            w_st  = 1;
          end else if (poke_req != poke_ack) begin
            wr_read  = 1'b1;
            poke_ack = poke_req;
          end
        end
        1: begin
          wr_busy = 1'b1;
          w_st    = 2;
        end
        default: begin
          if (beats == 0) begin
            wr_busy = 1'b0;
            w_st    = 0;
          end else if (rd_en && (!rand_wait || $urandom_range(0, 2) != 0)) begin
            rx_data_q.push_back(wr_writedata);
            rx_bc_q.push_back(wr_burstcount);
            rx_base_q.push_back(wr_baseaddress);
            wr_read = 1'b1;
            beats--;
          end
        end
      endcase
    end
  end

  // driver tasks
  task automatic start_frame(input logic [AW-1:0] base, input int words);
    @(negedge clk);
    frame_start = 1'b1;
    frame_base  = base;
    frame_words = FW'(words);
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic send_words(input int first, input int n);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 3000) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'(first + sent);
      if (in_ready) begin
        exp_q.push_back(in_data);
        sent++;
      end
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (sent != n) begin
      miscompares++;
      $display("FAIL send_words accepted %0d words, expected %0d", sent, n);
    end
  endtask

  task automatic wait_done(input int target, input string name);
    int guard = 0;
    while (done_cnt < target && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (done_cnt != target) begin
      miscompares++;
      $display("FAIL %s frame_done count got %0d want %0d", name, done_cnt, target);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; frame_start = 1'b0; frame_base = '0; frame_words = '0;
    in_valid = 1'b0; in_data = '0; rd_en = 1'b1; rand_wait = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (frame_active !== 1'b0) begin miscompares++; $display("FAIL reset frame_active got %b want 0", frame_active); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset frame_done got %b want 0", frame_done); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset in_ready got %b want 0", in_ready); end
    vectors++; if (wr_start !== 1'b0) begin miscompares++; $display("FAIL reset wr_start got %b want 0", wr_start); end
    vectors++; if (wr_baseaddress !== '0) begin miscompares++; $display("FAIL reset wr_baseaddress got %h want 0", wr_baseaddress); end
    vectors++; if (wr_burstcount !== '0) begin miscompares++; $display("FAIL reset wr_burstcount got %h want 0", wr_burstcount); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset underflow got %b want 0", underflow); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL idle in_ready got %b want 0", in_ready); end
  endtask

  // 16 words -> 8+8 and 13 words -> 8+5, both at 0x1000 with a free-running writer
  task automatic test_bursts();
    int words_tab[2] = '{16, 13};
    for (int t = 0; t < 2; t++) begin
      int words = words_tab[t];
      int d0 = done_cnt;
      exp_q.delete();
      start_frame(32'h1000, words);
      vectors++; if (frame_active !== 1'b1) begin miscompares++; $display("FAIL bursts%0d frame_active got %b want 1", t, frame_active); end
      send_words(32'h100 * (t + 1), words);
      wait_done(d0 + 1, "bursts");
      repeat (4) @(negedge clk);
      vectors++; if (done_cnt != d0 + 1) begin miscompares++; $display("FAIL bursts%0d done pulses got %0d want 1", t, done_cnt - d0); end
      vectors++; if (frame_active !== 1'b0) begin miscompares++; $display("FAIL bursts%0d frame_active after done got %b want 0", t, frame_active); end
      vectors++; if (st_base_q.size() - st_idx != 2) begin miscompares++; $display("FAIL bursts%0d start count got %0d want 2", t, st_base_q.size() - st_idx); end
      for (int b = 0; b < 2 && st_idx + b < st_base_q.size(); b++) begin
        logic [AW-1:0] eb = 32'h1000 + AW'(32 * b);
        logic [BW-1:0] ec = BW'((b == 0) ? 8 : words - 8);
        vectors++;
        if (st_base_q[st_idx+b] !== eb || st_bc_q[st_idx+b] !== ec) begin
          miscompares++;
          $display("FAIL bursts%0d start%0d got base %h len %0d want base %h len %0d", t, b, st_base_q[st_idx+b], st_bc_q[st_idx+b], eb, ec);
        end
      end
      vectors++; if (rx_data_q.size() - rx_idx != words) begin miscompares++; $display("FAIL bursts%0d beats got %0d want %0d", t, rx_data_q.size() - rx_idx, words); end
      for (int i = 0; i < words && rx_idx + i < rx_data_q.size(); i++) begin
        logic [AW-1:0] eb = 32'h1000 + AW'(32 * (i / 8));
        logic [BW-1:0] ec = BW'((i < 8) ? 8 : words - 8);
        vectors++;
        if (rx_data_q[rx_idx+i] !== exp_q[i] || rx_bc_q[rx_idx+i] !== ec || rx_base_q[rx_idx+i] !== eb) begin
          miscompares++;
          $display("FAIL bursts%0d beat%0d got data %h len %0d base %h want data %h len %0d base %h", t, i, rx_data_q[rx_idx+i], rx_bc_q[rx_idx+i], rx_base_q[rx_idx+i], exp_q[i], ec, eb);
        end
      end
      st_idx = st_base_q.size();
      rx_idx = rx_data_q.size();
    end
  endtask

  // 7 words buffered must not start a burst; the 8th starts it one cycle later
  task automatic test_stall();
    int d0 = done_cnt;
    exp_q.delete();
    rand_wait = 1'b1;
    start_frame(32'h2000, 16);
    send_words(32'h300, 7);
    repeat (10) @(negedge clk);
    vectors++; if (wr_start !== 1'b0 || st_base_q.size() != st_idx) begin miscompares++; $display("FAIL stall early start got wr_start %b starts %0d want 0 0", wr_start, st_base_q.size() - st_idx); end
    send_words(32'h307, 1);
    vectors++; if (wr_start !== 1'b1 || wr_burstcount !== 4'd8 || wr_baseaddress !== 32'h2000) begin miscompares++; $display("FAIL stall start got %b len %0d base %h want 1 len 8 base 2000", wr_start, wr_burstcount, wr_baseaddress); end
    send_words(32'h308, 8);
    wait_done(d0 + 1, "stall");
    repeat (4) @(negedge clk);
    vectors++; if (st_base_q.size() - st_idx != 2) begin miscompares++; $display("FAIL stall start count got %0d want 2", st_base_q.size() - st_idx); end
    for (int b = 0; b < 2 && st_idx + b < st_base_q.size(); b++) begin
      vectors++;
      if (st_base_q[st_idx+b] !== 32'h2000 + AW'(32 * b) || st_bc_q[st_idx+b] !== 4'd8) begin
        miscompares++;
        $display("FAIL stall start%0d got base %h len %0d want base %h len 8", b, st_base_q[st_idx+b], st_bc_q[st_idx+b], 32'h2000 + AW'(32 * b));
      end
    end
    vectors++; if (rx_data_q.size() - rx_idx != 16) begin miscompares++; $display("FAIL stall beats got %0d want 16", rx_data_q.size() - rx_idx); end
    for (int i = 0; i < 16 && rx_idx + i < rx_data_q.size(); i++) begin
      vectors++;
      if (rx_data_q[rx_idx+i] !== exp_q[i]) begin miscompares++; $display("FAIL stall beat%0d got %h want %h", i, rx_data_q[rx_idx+i], exp_q[i]); end
    end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL stall underflow got %b want 0", underflow); end
    st_idx = st_base_q.size();
    rx_idx = rx_data_q.size();
    rand_wait = 1'b0;
  endtask

  // writer holds off reads: FIFO fills to 32, then drains 40 words in order
  task automatic test_backpressure();
    int d0 = done_cnt;
    exp_q.delete();
    rd_en = 1'b0;
    start_frame(32'h3000, 40);
    send_words(32'h400, 32);
    in_valid = 1'b1;
    in_data  = 32'h420;
    repeat (5) @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full in_ready got %b want 0", in_ready); end
    vectors++; if (st_base_q.size() - st_idx != 1) begin miscompares++; $display("FAIL full starts got %0d want 1", st_base_q.size() - st_idx); end
    in_valid = 1'b0;
    rd_en = 1'b1;
    send_words(32'h420, 8);
    wait_done(d0 + 1, "backpressure");
    repeat (4) @(negedge clk);
    vectors++; if (st_base_q.size() - st_idx != 5) begin miscompares++; $display("FAIL full start count got %0d want 5", st_base_q.size() - st_idx); end
    for (int b = 0; b < 5 && st_idx + b < st_base_q.size(); b++) begin
      vectors++;
      if (st_base_q[st_idx+b] !== 32'h3000 + AW'(32 * b) || st_bc_q[st_idx+b] !== 4'd8) begin
        miscompares++;
        $display("FAIL full start%0d got base %h len %0d want base %h len 8", b, st_base_q[st_idx+b], st_bc_q[st_idx+b], 32'h3000 + AW'(32 * b));
      end
    end
    vectors++; if (rx_data_q.size() - rx_idx != 40) begin miscompares++; $display("FAIL full beats got %0d want 40", rx_data_q.size() - rx_idx); end
    for (int i = 0; i < 40 && rx_idx + i < rx_data_q.size(); i++) begin
      vectors++;
      if (rx_data_q[rx_idx+i] !== 32'h400 + DW'(i)) begin miscompares++; $display("FAIL full beat%0d got %h want %h", i, rx_data_q[rx_idx+i], 32'h400 + DW'(i)); end
    end
    st_idx = st_base_q.size();
    rx_idx = rx_data_q.size();
  endtask

  task automatic test_zero_frame();
    int d0 = done_cnt;
    @(negedge clk);
    frame_start = 1'b1; frame_base = 32'h9000; frame_words = '0;
    @(negedge clk);
    frame_start = 1'b0;
    vectors++; if (frame_done !== 1'b1 || frame_active !== 1'b0) begin miscompares++; $display("FAIL zero done/active got %b %b want 1 0", frame_done, frame_active); end
    @(negedge clk);
    vectors++; if (frame_done !== 1'b0 || frame_active !== 1'b0) begin miscompares++; $display("FAIL zero after got %b %b want 0 0", frame_done, frame_active); end
    repeat (3) @(negedge clk);
    vectors++; if (done_cnt != d0 + 1 || st_base_q.size() != st_idx) begin miscompares++; $display("FAIL zero dones %0d starts %0d want 1 0", done_cnt - d0, st_base_q.size() - st_idx); end
  endtask

  task automatic test_ignore_start();
    int d0 = done_cnt;
    exp_q.delete();
    start_frame(32'h4000, 8);
    send_words(32'h500, 3);
    start_frame(32'h5000, 3);
    vectors++; if (frame_active !== 1'b1) begin miscompares++; $display("FAIL ignore frame_active got %b want 1", frame_active); end
    send_words(32'h503, 5);
    wait_done(d0 + 1, "ignore");
    repeat (4) @(negedge clk);
    vectors++; if (st_base_q.size() - st_idx != 1) begin miscompares++; $display("FAIL ignore start count got %0d want 1", st_base_q.size() - st_idx); end
    if (st_base_q.size() > st_idx) begin
      vectors++;
      if (st_base_q[st_idx] !== 32'h4000 || st_bc_q[st_idx] !== 4'd8) begin miscompares++; $display("FAIL ignore start got base %h len %0d want 4000 8", st_base_q[st_idx], st_bc_q[st_idx]); end
    end
    vectors++; if (rx_data_q.size() - rx_idx != 8) begin miscompares++; $display("FAIL ignore beats got %0d want 8", rx_data_q.size() - rx_idx); end
    for (int i = 0; i < 8 && rx_idx + i < rx_data_q.size(); i++) begin
      vectors++;
      if (rx_data_q[rx_idx+i] !== 32'h500 + DW'(i)) begin miscompares++; $display("FAIL ignore beat%0d got %h want %h", i, rx_data_q[rx_idx+i], 32'h500 + DW'(i)); end
    end
    st_idx = st_base_q.size();
    rx_idx = rx_data_q.size();
  endtask

  // read strobe on an empty FIFO: sticky flag, pointers untouched for the next frame
  task automatic test_underflow();
    int d0 = done_cnt;
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL underflow before got %b want 0", underflow); end
    poke_req++;
    repeat (2) @(negedge clk);
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL underflow set got %b want 1", underflow); end
    exp_q.delete();
    start_frame(32'h8000, 8);
    send_words(32'h600, 8);
    wait_done(d0 + 1, "underflow");
    repeat (4) @(negedge clk);
    vectors++; if (rx_data_q.size() - rx_idx != 8) begin miscompares++; $display("FAIL underflow beats got %0d want 8", rx_data_q.size() - rx_idx); end
    for (int i = 0; i < 8 && rx_idx + i < rx_data_q.size(); i++) begin
      vectors++;
      if (rx_data_q[rx_idx+i] !== 32'h600 + DW'(i)) begin miscompares++; $display("FAIL underflow beat%0d got %h want %h", i, rx_data_q[rx_idx+i], 32'h600 + DW'(i)); end
    end
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL underflow sticky got %b want 1", underflow); end
    st_idx = st_base_q.size();
    rx_idx = rx_data_q.size();
  endtask

  task automatic test_reset_mid_frame();
    int d0 = done_cnt;
    exp_q.delete();
    start_frame(32'h6000, 16);
    send_words(32'h700, 12);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (frame_active !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b0 || wr_start !== 1'b0 ||
        wr_baseaddress !== '0 || wr_burstcount !== '0 || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset outputs active %b done %b ready %b start %b base %h len %0d uf %b want all 0",
               frame_active, frame_done, in_ready, wr_start, wr_baseaddress, wr_burstcount, underflow);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (done_cnt != d0) begin miscompares++; $display("FAIL midreset frame_done pulses got %0d want 0", done_cnt - d0); end
    st_idx = st_base_q.size();
    rx_idx = rx_data_q.size();
    exp_q.delete();
    start_frame(32'h7000, 8);
    send_words(32'h800, 8);
    wait_done(d0 + 1, "midreset");
    repeat (4) @(negedge clk);
    vectors++; if (st_base_q.size() - st_idx != 1) begin miscompares++; $display("FAIL midreset start count got %0d want 1", st_base_q.size() - st_idx); end
    if (st_base_q.size() > st_idx) begin
      vectors++;
      if (st_base_q[st_idx] !== 32'h7000 || st_bc_q[st_idx] !== 4'd8) begin miscompares++; $display("FAIL midreset start got base %h len %0d want 7000 8", st_base_q[st_idx], st_bc_q[st_idx]); end
    end
    vectors++; if (rx_data_q.size() - rx_idx != 8) begin miscompares++; $display("FAIL midreset beats got %0d want 8", rx_data_q.size() - rx_idx); end
    for (int i = 0; i < 8 && rx_idx + i < rx_data_q.size(); i++) begin
      vectors++;
      if (rx_data_q[rx_idx+i] !== 32'h800 + DW'(i)) begin miscompares++; $display("FAIL midreset beat%0d got %h want %h", i, rx_data_q[rx_idx+i], 32'h800 + DW'(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_bursts();
    test_stall();
    test_backpressure();
    test_zero_frame();
    test_ignore_start();
    test_underflow();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wf_burst_feeder.md
Name: wf_burst_feeder

Overview:
Upstream stage for the Avalon-MM burst write master. Buffers a streaming pixel/word source in an internal show-ahead FIFO and cuts the frame into bursts: for each burst it presents base address and burst length, pulses the writer's start input, and serves write data word by word on the writer's read strobe. Sits between the capture/stream logic and the burst writer's ctrl_* port.

Parameters:
ADDRESS_WIDTH, 32, width of byte address to the writer
DATA_WIDTH, 32, stream/word width; must be a multiple of 8
BURST_WIDTH, 4, width of burst length field; must hold BURST_COUNT
BURST_COUNT, 8, nominal words per burst, 1..2^BURST_WIDTH-1
FIFO_AW, 5, log2 of FIFO depth (depth 32)
FRAME_WIDTH, 20, width of the frame word counter

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse: begin a frame
frame_base  in  ADDRESS_WIDTH  byte base address, sampled on frame_start
frame_words  in  FRAME_WIDTH  words in frame, sampled on frame_start
frame_active  out  1  high from accepted frame_start until frame_done
frame_done  out  1  one-cycle pulse after last burst completes
in_valid  in  1  stream word valid
in_data  in  DATA_WIDTH  stream word
in_ready  out  1  stream word accepted when in_valid && in_ready
wr_start  out  1  to writer ctrl_start
wr_baseaddress  out  ADDRESS_WIDTH  to writer ctrl_baseaddress
wr_burstcount  out  BURST_WIDTH  to writer ctrl_burstcount
wr_busy  in  1  from writer ctrl_busy
wr_read  in  1  from writer ctrl_read: current word consumed this cycle
wr_writedata  out  DATA_WIDTH  to writer ctrl_writedata; FIFO head, combinational
underflow  out  1  sticky: wr_read seen with FIFO empty

Behaviour:
- Reset (async, reset_n=0): state IDLE, FIFO emptied (pointers/count 0), all outputs 0 (wr_writedata reflects empty RAM head, don't-care), underflow cleared.
- FIFO: depth 2^FIFO_AW, show-ahead; wr_writedata = head word, valid same cycle as wr_read. Push = in_valid && in_ready; pop = wr_read. Simultaneous push+pop: count unchanged, both happen. Count width FIFO_AW+1.
- in_ready = frame_active && (count < depth) && (words_accepted < frame_words). Words beyond frame_words are never accepted.
- wr_read with count==0: no pop, pointers unchanged, underflow<=1 until reset.
- FSM:
  IDLE: frame_start -> latch base into addr, frame_words into remaining, clear words_accepted; frame_active<=1; go FILL. frame_start with frame_words==0 -> frame_done pulse next cycle, frame_active stays 0.
  FILL: len = min(BURST_COUNT, remaining). When count >= len and wr_busy==0 -> drive wr_baseaddress=addr, wr_burstcount=len, wr_start=1 for exactly one cycle; go ARM.
  ARM: wait wr_busy==1 (normally next cycle); go BURST.
  BURST: wait wr_busy==0. Then addr <= addr + len*(DATA_WIDTH/8) (wraps modulo 2^ADDRESS_WIDTH), remaining <= remaining - len. If new remaining==0 -> DONE, else FILL.
  DONE: frame_done=1 one cycle, frame_active<=0, go IDLE.
- wr_baseaddress/wr_burstcount held stable from wr_start through end of BURST (writer compares against burstcount every beat).
- frame_start while frame_active: ignored.
- Final burst may be partial (remaining < BURST_COUNT); it waits only for len words.
- Latency: first wr_start at earliest 1 cycle after FIFO count reaches len.
- Reset mid-frame: everything aborted, buffered data discarded, no frame_done.

Test Plan:
- frame_base=0x1000, frame_words=16, BURST_COUNT=8, stream 0..15 back-to-back, writer model with no waitrequest -> two wr_start pulses, base 0x1000 then 0x1020, burstcount 8, writer receives 0..15 in order, one frame_done.
- frame_words=13 -> bursts of 8 then 5 at 0x1000/0x1020, wr_burstcount=5 held through second burst, frame_done after 13 words.
- Stream stalls with 7 words buffered -> no wr_start until 8th word arrives; writer waitrequest random -> data order preserved, no underflow.
- Writer never reads, 40 words offered -> in_ready drops at count 32, no data lost or duplicated after reads resume.
- frame_words=0 -> frame_done one cycle after frame_start, no wr_start; frame_start during active frame ignored; reset_n low mid-burst -> all outputs 0 immediately, next frame completes normally.
- wr_read forced with FIFO empty -> underflow=1 and stays 1 until reset.
